// File: rtl/open_drain_pkg.sv
// -----------------------------------------------------------------------------
// open_drain_pkg
//
// Shared definitions for the open-drain pair bring-up block:
//   - state_e               : controller FSM states of the ping/reply exchange
//   - TICK_INTERVAL_DEFAULT : clock cycles per protocol tick on the board clock
//   - state_after           : successor of a state once its tick has arrived
// -----------------------------------------------------------------------------
package open_drain_pkg;

    typedef enum logic [2:0] {
        S_WAIT = 3'd0,
        S_TX1  = 3'd1,
        S_GAP1 = 3'd2,
        S_TX2  = 3'd3,
        S_GAP2 = 3'd4,
        S_DONE = 3'd5
    } state_e;

    localparam int TICK_INTERVAL_DEFAULT = 12_000_000;

    // The exchange is a fixed linear walk; S_DONE holds and any
    // unreachable encoding falls back to the start of the exchange.
    function automatic logic [2:0] state_after(input logic [2:0] cur);
        logic [2:0] nxt;
        case (cur)
            S_WAIT:  nxt = S_TX1;
            S_TX1:   nxt = S_GAP1;
            S_GAP1:  nxt = S_TX2;
            S_TX2:   nxt = S_GAP2;
            S_GAP2:  nxt = S_DONE;
            S_DONE:  nxt = S_DONE;
            default: nxt = S_WAIT;
        endcase
        return nxt;
    endfunction

endpackage

// File: rtl/open_drain_if.sv
// -----------------------------------------------------------------------------
// open_drain_if
//
// Status bundle of the open-drain pair bring-up block (four board LEDs).
//   led_recv_1_o : node 1 has seen the node 2 reply
//   led_done_1_o : node 1 exchange completed
//   led_recv_2_o : node 2 has seen the node 1 ping
//   led_done_2_o : node 2 exchange completed
// Modports:
//   master : the block driving the LEDs
//   slave  : whatever observes them (board, bench)
// -----------------------------------------------------------------------------
interface open_drain_if;

    logic led_recv_1_o;
    logic led_done_1_o;
    logic led_recv_2_o;
    logic led_done_2_o;

    modport master (
        output led_recv_1_o,
        output led_done_1_o,
        output led_recv_2_o,
        output led_done_2_o
    );

    modport slave (
        input led_recv_1_o,
        input led_done_1_o,
        input led_recv_2_o,
        input led_done_2_o
    );

endinterface

// File: rtl/open_drain_node.sv
// -----------------------------------------------------------------------------
// open_drain_node
//
// One open-drain node: drives its pin low or releases it, samples the pin
// back and keeps a sticky "saw the other node" flag.
//
// Ports:
//   clk_i       in    system clock (rising edge)
//   rst_ni      in    asynchronous active-low reset
//   drive_low_i in    1 = pull the pin low, 0 = release (high-Z)
//   pin_io      inout open-drain pin, only ever 1'b0 or 1'bz
//   rx_o        out   registered pin value (reset value 1)
//   recv_o      out   sticky: a low was seen that this node did not cause
//
// Build option OD_INPUT_SYNC_EN:
//   defined   -> pin passes a two-flop synchronizer, rx_o is the second flop
//   undefined -> a single sampling register, rx_o is that register
// -----------------------------------------------------------------------------
module open_drain_node (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic drive_low_i,
    inout  wire  pin_io,
    output logic rx_o,
    output logic recv_o
);

    // Open drain: never drive a 1, the external pull-up supplies it.
    assign pin_io = drive_low_i ? 1'b0 : 1'bz;

    // sample_next is the value rx_o takes at the coming edge; drive_at_sample
    // is this node's own drive at the moment that value was taken from the
    // pin, so the last samples of our own pulse still in flight are not
    // mistaken for the other node once we release.
    logic sample_next;
    logic drive_at_sample;

`ifdef OD_INPUT_SYNC_EN
    logic sync_p0;
    logic rx_p1;
    logic drv_p0;

    // Stage p0: first synchronizer flop plus the matching drive history
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            sync_p0 <= 1'b1;
            drv_p0  <= 1'b0;
        end else begin
            sync_p0 <= pin_io;
            drv_p0  <= drive_low_i;
        end
    end

    // Stage p1: second synchronizer flop, the node's rx value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_p1 <= 1'b1;
        end else begin
            rx_p1 <= sync_p0;
        end
    end

    assign sample_next     = sync_p0;
    assign drive_at_sample = drv_p0;
    assign rx_o            = rx_p1;
`else
    logic rx_p0;

    // Stage p0: single sampling register, the node's rx value
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            rx_p0 <= 1'b1;
        end else begin
            rx_p0 <= pin_io;
        end
    end

    assign sample_next     = pin_io;
    assign drive_at_sample = drive_low_i;
    assign rx_o            = rx_p0;
`endif

    // Recv flag rises on the same edge rx_o goes low, so the LED latency
    // equals the sampling depth.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            recv_o <= 1'b0;
        end else if (!sample_next && !drive_at_sample) begin
            recv_o <= 1'b1;
        end
    end

endmodule

// File: rtl/open_drain_pair_test.sv
// -----------------------------------------------------------------------------
// open_drain_pair_test
//
// Bring-up block for a wired-AND line: node 1 pings (pulls low for one tick),
// node 2 replies (pulls low for one tick), each node reports whether it saw
// the other, and after a final quiet tick both report completion if the line
// is released again. On the board pin1_io and pin2_io share one pulled-up net.
//
// Parameters:
//   tick_interval  clock cycles per protocol tick (>= 2)
//
// Ports:
//   clk_i    in     system clock (rising edge)
//   rst_ni   in     asynchronous active-low reset
//   pin1_io  inout  node 1 open-drain pin (1'b0 or 1'bz)
//   pin2_io  inout  node 2 open-drain pin (1'b0 or 1'bz)
//   led      open_drain_if.master  recv/done LEDs for both nodes
//
// Build option OD_INPUT_SYNC_EN (see open_drain_node): two-flop input
// synchronizers instead of a single sampling register.
// -----------------------------------------------------------------------------
module open_drain_pair_test
    import open_drain_pkg::*;
#(
    parameter int tick_interval = TICK_INTERVAL_DEFAULT
) (
    input  logic clk_i,
    input  logic rst_ni,
    inout  wire  pin1_io,
    inout  wire  pin2_io,
    open_drain_if.master led
);

    localparam int CNT_W = $clog2(tick_interval);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(tick_interval - 1);

    localparam logic [2:0] ST_WAIT = S_WAIT;
    localparam logic [2:0] ST_TX1  = S_TX1;
    localparam logic [2:0] ST_TX2  = S_TX2;
    localparam logic [2:0] ST_GAP2 = S_GAP2;

    logic [CNT_W-1:0] tick_cnt;
    logic             tick;
    logic [2:0]       state_q;
    logic [2:0]       state_d;
    logic             drv1_q;
    logic             drv2_q;
    logic             rx1;
    logic             rx2;
    logic             recv1;
    logic             recv2;
    logic             done1_q;
    logic             done2_q;

    // Free-running tick counter; it never stops, so every non-terminal
    // state lasts exactly tick_interval cycles.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            tick_cnt <= '0;
        end else if (tick) begin
            tick_cnt <= '0;
        end else begin
            tick_cnt <= tick_cnt + CNT_W'(1);
        end
    end

    assign tick = (tick_cnt == CNT_LAST);

    always_comb begin
        state_d = state_q;
        if (tick) begin
            state_d = state_after(state_q);
        end
    end

    // Drive enables are registered from the next state so the pins switch
    // cleanly on the same edge as the state, with no decode glitches.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= ST_WAIT;
            drv1_q  <= 1'b0;
            drv2_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            drv1_q  <= (state_d == ST_TX1);
            drv2_q  <= (state_d == ST_TX2);
        end
    end

    open_drain_node u_node1 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .drive_low_i (drv1_q),
        .pin_io      (pin1_io),
        .rx_o        (rx1),
        .recv_o      (recv1)
    );

    open_drain_node u_node2 (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .drive_low_i (drv2_q),
        .pin_io      (pin2_io),
        .rx_o        (rx2),
        .recv_o      (recv2)
    );

    // Completion is judged once, on the closing tick of the quiet gap: a
    // line still held low means someone is stuck, so nothing is reported.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done1_q <= 1'b0;
            done2_q <= 1'b0;
        end else if (tick && (state_q == ST_GAP2) && rx1 && rx2) begin
            done1_q <= recv1;
            done2_q <= recv2;
        end
    end

    assign led.led_recv_1_o = recv1;
    assign led.led_recv_2_o = recv2;
    assign led.led_done_1_o = done1_q;
    assign led.led_done_2_o = done2_q;

endmodule

// File: tb/tb_open_drain_pair_test.sv
// -----------------------------------------------------------------------------
// tb_open_drain_pair_test
//
// dut_a: both pins on one pulled-up net (the board wiring), plus an optional
//        external low driver to emulate a stuck line.
// dut_b: each pin on its own pulled-up net (open pins), nobody else drives.
// Expected LEDs and net levels come from a line-level model: which node owns
// the line in each cycle, what each node samples LAT cycles later, and
// whether that low was caused by someone else.
// -----------------------------------------------------------------------------
module tb_open_drain_pair_test;
    import open_drain_pkg::*;

    localparam int N    = 10;
    localparam int MAXK = 256;
`ifdef OD_INPUT_SYNC_EN
    localparam int LAT = 2;
`else
    localparam int LAT = 1;
`endif

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    logic ext_low = 1'b0;

    always #5 clk = ~clk;

    wire net_a;
    wire net_b1;
    wire net_b2;
    pullup (net_a);
    pullup (net_b1);
    pullup (net_b2);
    assign net_a = ext_low ? 1'b0 : 1'bz;

    open_drain_if led_a ();
    open_drain_if led_b ();

    open_drain_pair_test #(.tick_interval(N)) dut_a (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .pin1_io (net_a),
        .pin2_io (net_a),
        .led     (led_a)
    );

    open_drain_pair_test #(.tick_interval(N)) dut_b (
        .clk_i   (clk),
        .rst_ni  (rst_n),
        .pin1_io (net_b1),
        .pin2_io (net_b2),
        .led     (led_b)
    );

    int vectors     = 0;
    int miscompares = 0;

    // Model state: k = edges since reset release, ext_hist[m] = external
    // low driver active in the interval after edge m.
    int k = 0;
    bit ext_hist [MAXK];
    bit ea_r1, ea_r2, ea_d1, ea_d2;
    bit eb_r1, eb_r2, eb_d1, eb_d2;

    function automatic int phase(input int m);
        int p;
        p = m / N;
        return (p > 5) ? 5 : p;
    endfunction

    function automatic bit own1(input int m);
        return (m >= 0) && (phase(m) == 1);
    endfunction

    function automatic bit own2(input int m);
        return (m >= 0) && (phase(m) == 3);
    endfunction

    function automatic bit line_a(input int m);
        if (m < 0) return 1'b1;
        return !(own1(m) || own2(m) || ext_hist[m]);
    endfunction

    function automatic bit line_b1(input int m);
        return !own1(m);
    endfunction

    function automatic bit line_b2(input int m);
        return !own2(m);
    endfunction

    task automatic chk(input string name, input logic obs, input logic exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%b expected=%b", name, k, obs, exp);
        end
    endtask

    task automatic chk_state(input string name, input logic [2:0] obs, input logic [2:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s k=%0d observed=%0d expected=%0d", name, k, obs, exp);
        end
    endtask

    // Called mid-cycle; asserts reset, checks the immediate release, holds,
    // and deasserts mid-cycle so the next rising edge is edge 1.
    task automatic apply_reset(input int hold_cycles);
        rst_n = 1'b0;
        #1;
        chk("rst a_recv1", led_a.led_recv_1_o, 1'b0);
        chk("rst a_recv2", led_a.led_recv_2_o, 1'b0);
        chk("rst a_done1", led_a.led_done_1_o, 1'b0);
        chk("rst a_done2", led_a.led_done_2_o, 1'b0);
        chk("rst b_recv1", led_b.led_recv_1_o, 1'b0);
        chk("rst b_done2", led_b.led_done_2_o, 1'b0);
        chk("rst net_a",   net_a,  1'b1);
        chk("rst net_b1",  net_b1, 1'b1);
        chk("rst net_b2",  net_b2, 1'b1);
        repeat (hold_cycles) @(posedge clk);
        #3;
        k = 0;
        for (int i = 0; i < MAXK; i++) ext_hist[i] = 1'b0;
        {ea_r1, ea_r2, ea_d1, ea_d2} = 4'b0;
        {eb_r1, eb_r2, eb_d1, eb_d2} = 4'b0;
        rst_n = 1'b1;
    endtask

    task automatic run_cycles(input int ncyc, input int ext_from);
        int m;
        for (int i = 0; i < ncyc; i++) begin
            @(posedge clk);
            #1;
            k++;
            ext_low = (ext_from >= 0) && (k >= ext_from);
            if (k < MAXK) ext_hist[k] = ext_low;
            if (k == 5 * N) begin
                // Closing tick of the quiet gap: both nodes must see a high line.
                ea_d1 = line_a(k - 1 - LAT) ? ea_r1 : 1'b0;
                ea_d2 = line_a(k - 1 - LAT) ? ea_r2 : 1'b0;
                eb_d1 = (line_b1(k - 1 - LAT) && line_b2(k - 1 - LAT)) ? eb_r1 : 1'b0;
                eb_d2 = (line_b1(k - 1 - LAT) && line_b2(k - 1 - LAT)) ? eb_r2 : 1'b0;
            end
            m = k - LAT;
            if (m >= 0) begin
                if (!line_a(m)  && !own1(m)) ea_r1 = 1'b1;
                if (!line_a(m)  && !own2(m)) ea_r2 = 1'b1;
                if (!line_b1(m) && !own1(m)) eb_r1 = 1'b1;
                if (!line_b2(m) && !own2(m)) eb_r2 = 1'b1;
            end
            #1;
            chk("a_recv1", led_a.led_recv_1_o, ea_r1);
            chk("a_recv2", led_a.led_recv_2_o, ea_r2);
            chk("a_done1", led_a.led_done_1_o, ea_d1);
            chk("a_done2", led_a.led_done_2_o, ea_d2);
            chk("b_recv1", led_b.led_recv_1_o, eb_r1);
            chk("b_recv2", led_b.led_recv_2_o, eb_r2);
            chk("b_done1", led_b.led_done_1_o, eb_d1);
            chk("b_done2", led_b.led_done_2_o, eb_d2);
            chk("net_a",   net_a,  line_a(k));
            chk("net_b1",  net_b1, line_b1(k));
            chk("net_b2",  net_b2, line_b2(k));
        end
    endtask

    task automatic scenario_normal();
        apply_reset($urandom_range(1, 3));
        run_cycles(5 * N + $urandom_range(5, 20), -1);
        chk("normal a_done1 final", led_a.led_done_1_o, 1'b1);
        chk("normal a_done2 final", led_a.led_done_2_o, 1'b1);
        chk("open b_recv1 final",   led_b.led_recv_1_o, 1'b0);
        chk("open b_done2 final",   led_b.led_done_2_o, 1'b0);
        chk_state("normal a_state", dut_a.state_q, 3'(S_DONE));
    endtask

    task automatic scenario_stuck();
        int from;
        from = 2 * N + $urandom_range(0, N - 1);
        apply_reset($urandom_range(1, 3));
        run_cycles(5 * N + $urandom_range(5, 15), from);
        chk("stuck a_done1 final", led_a.led_done_1_o, 1'b0);
        chk("stuck a_done2 final", led_a.led_done_2_o, 1'b0);
        chk_state("stuck a_state", dut_a.state_q, 3'(S_DONE));
        ext_low = 1'b0;
    endtask

    task automatic scenario_midreset();
        apply_reset($urandom_range(1, 3));
        run_cycles(3 * N + $urandom_range(0, N - 1), -1);
        chk_state("mid a_state_tx2", dut_a.state_q, 3'(S_TX2));
        apply_reset($urandom_range(1, 4));
        run_cycles(5 * N + $urandom_range(5, 15), -1);
        chk("mid a_done1 final", led_a.led_done_1_o, 1'b1);
        chk("mid a_done2 final", led_a.led_done_2_o, 1'b1);
        chk_state("mid a_state", dut_a.state_q, 3'(S_DONE));
    endtask

    initial begin
        #12;
        scenario_normal();
        scenario_stuck();
        scenario_midreset();
        for (int it = 0; it < 4; it++) begin
            case ($urandom_range(0, 2))
                0:       scenario_normal();
                1:       scenario_stuck();
                default: scenario_midreset();
            endcase
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
